// File: rtl/triggerrec_pkg.sv
// triggerrec_pkg: event word layout and FSM state codes shared by the trigger recorder and player.
package triggerrec_pkg;
    localparam int EV_WIDTH   = 64;
    localparam int EV_IO_LSB  = 48;
    localparam int EV_END_BIT = 47;
    localparam int EV_TS_MSB  = 46;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/triggerplay_sync_edge.sv
// triggerplay_sync_edge: 2FF synchroniser with rising-edge pulse for an async trigger input.
// Only compiled when TRIGGERPLAY_EXT_TRIG_EN is defined.
`ifdef TRIGGERPLAY_EXT_TRIG_EN
module triggerplay_sync_edge (
    input  logic clk_fast,
    input  logic resetn,
    input  logic i_async,
    output logic o_rise
);
    logic [2:0] r_sh;
    always_ff @(posedge clk_fast) begin
        if (!resetn) r_sh <= '0;
        else         r_sh <= {r_sh[1:0], i_async};
    end
    assign o_rise = r_sh[1] & ~r_sh[2];
endmodule
`endif

// File: rtl/triggerplay_engine.sv
// triggerplay_engine: replays timestamped GPIO events from the event FIFO against a free-running counter.
// Define TRIGGERPLAY_EXT_TRIG_EN to add ext_trig and the ARM state that waits for its rising edge.
module triggerplay_engine
    import triggerrec_pkg::*;
#(
    parameter int                   IO_LENGTH  = 16,
    parameter int                   TS_WIDTH   = 47,
    parameter logic [IO_LENGTH-1:0] IDLE_LEVEL = '0
) (
    input  logic                 clk_fast,
    input  logic                 resetn,
    input  logic                 i_cmd_start,
    input  logic                 i_cmd_stop,
    input  logic                 i_cnt_load,
    input  logic [63:0]          i_cnt_value,
    input  logic [EV_WIDTH-1:0]  i_ev_data,
    input  logic                 i_ev_nempty,
`ifdef TRIGGERPLAY_EXT_TRIG_EN
    input  logic                 i_ext_trig,
`endif
    output logic                 o_ev_pop,
    output logic [IO_LENGTH-1:0] o_io_out,
    output logic                 o_io_oe,
    output logic [63:0]          o_counter,
    output logic [2:0]           o_state,
    output logic [31:0]          o_played,
    output logic [15:0]          o_late
);
    state_t               r_state, w_next;
    logic [IO_LENGTH-1:0] r_io_out;
    logic                 r_io_oe;
    logic [63:0]          r_counter;
    logic [31:0]          r_played;
    logic [15:0]          r_late;
    logic                 w_due, w_is_late, w_start, w_arm_go;

`ifdef TRIGGERPLAY_EXT_TRIG_EN
    localparam state_t START_ST = ST_ARM;
    triggerplay_sync_edge u_sync (
        .clk_fast (clk_fast),
        .resetn   (resetn),
        .i_async  (i_ext_trig),
        .o_rise   (w_arm_go)
    );
`else
    localparam state_t START_ST = ST_RUN;
    assign w_arm_go = 1'b0;
`endif

    // stop wins over a coincident due event so the head stays in the FIFO
    assign w_due     = r_state == ST_RUN && i_ev_nempty && !i_cmd_stop &&
                       r_counter[TS_WIDTH-1:0] >= i_ev_data[TS_WIDTH-1:0];
    assign w_is_late = r_counter[TS_WIDTH-1:0] > i_ev_data[TS_WIDTH-1:0];
    assign w_start   = i_cmd_start && !i_cmd_stop && (r_state == ST_IDLE || r_state == ST_DONE);

    always_ff @(posedge clk_fast) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: w_next = i_cmd_start ? START_ST : r_state;
            ST_ARM:           w_next = w_arm_go ? ST_RUN : ST_ARM;
            ST_RUN:           w_next = w_due ? (i_ev_data[EV_END_BIT] ? ST_DONE : ST_SETTLE) : ST_RUN;
            ST_SETTLE:        w_next = ST_RUN;
            default:          w_next = ST_IDLE;
        endcase
        if (i_cmd_stop) w_next = ST_IDLE;
    end

    assign o_ev_pop = w_due;

    always_ff @(posedge clk_fast) begin
        if (!resetn) begin
            r_io_out  <= IDLE_LEVEL;
            r_io_oe   <= 1'b0;
            r_counter <= '0;
            r_played  <= '0;
            r_late    <= '0;
        end else begin
            if (i_cnt_load)
                r_counter <= i_cnt_value;
            else if (r_state == ST_RUN || r_state == ST_SETTLE)
                r_counter <= r_counter + 64'd1;
            if (i_cmd_stop)
                r_io_oe <= 1'b0;
            else if (w_start) begin
                r_io_oe  <= 1'b1;
                r_played <= '0;
                r_late   <= '0;
            end
            if (w_due) begin
                r_io_out <= i_ev_data[EV_IO_LSB +: IO_LENGTH];
                r_played <= r_played + 32'd1;
                if (w_is_late) r_late <= r_late + 16'(r_late != 16'hFFFF);
            end
        end
    end

    assign o_io_out  = r_io_out;
    assign o_io_oe   = r_io_oe;
    assign o_counter = r_counter;
    assign o_state   = r_state;
    assign o_played  = r_played;
    assign o_late    = r_late;
endmodule

// File: tb/tb_triggerplay_engine.sv
// tb_triggerplay_engine: scoreboard bench; expected pop times come from the max(ts, prev+2) playback rule.
// Define TRIGGERPLAY_EXT_TRIG_EN to exercise the ARM/ext_trig path as well.
module tb_triggerplay_engine;
    typedef struct {
        logic [15:0] io;
        logic [63:0] p;
    } exp_t;

    logic        clk_fast = 0, resetn = 0;
    logic        i_cmd_start = 0, i_cmd_stop = 0, i_cnt_load = 0, i_ev_nempty = 0;
    logic [63:0] i_cnt_value = 0, i_ev_data = 0;
`ifdef TRIGGERPLAY_EXT_TRIG_EN
    logic        i_ext_trig = 0;
`endif
    logic        o_ev_pop, o_io_oe;
    logic [15:0] o_io_out, o_late;
    logic [63:0] o_counter;
    logic [2:0]  o_state;
    logic [31:0] o_played;

    exp_t        sb[$];
    logic [63:0] fifo[$], evq[$];
    logic [63:0] m_ld;
    logic [15:0] io_exp;
    bit          pop_pend = 0, io_pend = 0, prev_pop = 0;
    int          n_vec = 0, n_err = 0;

    triggerplay_engine dut (
        .clk_fast    (clk_fast),
        .resetn      (resetn),
        .i_cmd_start (i_cmd_start),
        .i_cmd_stop  (i_cmd_stop),
        .i_cnt_load  (i_cnt_load),
        .i_cnt_value (i_cnt_value),
        .i_ev_data   (i_ev_data),
        .i_ev_nempty (i_ev_nempty),
`ifdef TRIGGERPLAY_EXT_TRIG_EN
        .i_ext_trig  (i_ext_trig),
`endif
        .o_ev_pop    (o_ev_pop),
        .o_io_out    (o_io_out),
        .o_io_oe     (o_io_oe),
        .o_counter   (o_counter),
        .o_state     (o_state),
        .o_played    (o_played),
        .o_late      (o_late)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_fast);
        #1;
    endtask

    // FIFO model: head is presented after each edge; a pop seen in the previous cycle is consumed here
    always @(posedge clk_fast) begin
        #1;
        if (pop_pend && fifo.size() != 0) void'(fifo.pop_front());
        pop_pend    = 0;
        i_ev_nempty = fifo.size() != 0;
        i_ev_data   = (fifo.size() != 0) ? fifo[0] : 64'd0;
    end

    always @(negedge clk_fast) begin
        exp_t e;
        if (io_pend) begin
            chk("io_out_after_pop", {48'd0, o_io_out}, {48'd0, io_exp});
            io_pend = 0;
        end
        if (o_ev_pop) begin
            chk("pop_while_empty", {63'd0, i_ev_nempty}, 64'd1);
            chk("pop_back_to_back", {63'd0, prev_pop}, 64'd0);
            if (sb.size() == 0) chk("unexpected_pop", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("pop_counter", o_counter, e.p);
                io_exp  = e.io;
                io_pend = 1;
            end
            pop_pend = 1;
        end
        prev_pop = o_ev_pop;
    end

    task automatic do_start;
        i_cmd_start = 1;
        tick;
        i_cmd_start = 0;
`ifdef TRIGGERPLAY_EXT_TRIG_EN
        repeat (50) tick;
        chk("arm_state", {61'd0, o_state}, 64'd1);
        chk("arm_counter_frozen", o_counter, m_ld);
        i_ext_trig = 1;
        tick;
        i_ext_trig = 0;
        tick;
        chk("arm_before_sync", {61'd0, o_state}, 64'd1);
        tick;
        chk("run_after_trig", {61'd0, o_state}, 64'd2);
        chk("counter_at_trig", o_counter, m_ld);
`endif
    endtask

    task automatic prep(input logic [63:0] ld);
        i_cmd_stop = 1;
        tick;
        i_cmd_stop = 0;
        fifo.delete();
        sb.delete();
        i_cnt_load  = 1;
        i_cnt_value = ld;
        tick;
        i_cnt_load = 0;
        m_ld       = ld;
    endtask

    task automatic wait_drain(input string nm);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 3000) begin
            tick;
            cyc++;
        end
        if (sb.size() != 0) chk({nm, "_timeout"}, 64'(sb.size()), 64'd0);
        repeat (3) tick;
    endtask

    // expected pop count: first event no earlier than the load value, then at least 2 counts apart
    task automatic run_scn(input string nm, input logic [63:0] ld);
        logic [63:0] p, ts;
        int          lt = 0;
        exp_t        e;
        logic        dn;
        prep(ld);
        p = ld;
        foreach (evq[k]) begin
            ts = {17'd0, evq[k][46:0]};
            if (k != 0) p = p + 64'd2;
            if (ts > p) p = ts;
            if (p > ts) lt++;
            e.io = evq[k][63:48];
            e.p  = p;
            sb.push_back(e);
            fifo.push_back(evq[k]);
        end
        dn = evq[evq.size()-1][47];
        tick;
        do_start();
        wait_drain(nm);
        chk({nm, "_played"}, {32'd0, o_played}, 64'(evq.size()));
        chk({nm, "_late"}, {48'd0, o_late}, 64'(lt));
        chk({nm, "_io_last"}, {48'd0, o_io_out}, {48'd0, evq[evq.size()-1][63:48]});
        chk({nm, "_oe"}, {63'd0, o_io_oe}, 64'd1);
        chk({nm, "_state"}, {61'd0, o_state}, dn ? 64'd4 : 64'd2);
        if (dn) chk({nm, "_counter_frozen"}, o_counter, p + 64'd1);
    endtask

    function automatic logic [63:0] ev(input logic [15:0] io, input logic e, input logic [46:0] ts);
        return {io, e, ts};
    endfunction

    task automatic chk_reset(input string nm);
        chk({nm, "_state"}, {61'd0, o_state}, 64'd0);
        chk({nm, "_io_out"}, {48'd0, o_io_out}, 64'd0);
        chk({nm, "_oe"}, {63'd0, o_io_oe}, 64'd0);
        chk({nm, "_counter"}, o_counter, 64'd0);
        chk({nm, "_played"}, {32'd0, o_played}, 64'd0);
        chk({nm, "_late"}, {48'd0, o_late}, 64'd0);
        chk({nm, "_pop"}, {63'd0, o_ev_pop}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        int          n;
        logic [46:0] ts;
        logic [15:0] io;
        repeat (3) tick;
        chk_reset("reset");
        resetn = 1;
        tick;

        evq = '{ev(16'h0001, 1'b0, 47'd10), ev(16'h0003, 1'b0, 47'd20)};
        run_scn("two_events", 64'd0);

        evq = '{ev(16'hBEEF, 1'b1, 47'd50)};
        run_scn("late_event", 64'd100);

        evq = '{ev(16'h0011, 1'b0, 47'd5), ev(16'h0022, 1'b0, 47'd5), ev(16'h0033, 1'b1, 47'd5)};
        run_scn("same_ts", 64'd0);

        prep(64'd0);
        tick;
        do_start();
        repeat (200) tick;
        chk("empty_played", {32'd0, o_played}, 64'd0);
        chk("empty_state", {61'd0, o_state}, 64'd2);
        e.io = 16'h5A5A;
        e.p  = 64'd300;
        sb.push_back(e);
        fifo.push_back(ev(16'h5A5A, 1'b1, 47'd300));
        wait_drain("empty_wait");
        chk("empty_done_state", {61'd0, o_state}, 64'd4);
        chk("empty_done_counter", o_counter, 64'd301);
        chk("empty_done_late", {48'd0, o_late}, 64'd0);

        for (int s = 0; s < 8; s++) begin
            evq.delete();
            n  = $urandom_range(1, 6);
            ts = 47'($urandom_range(0, 40));
            for (int k = 0; k < n; k++) begin
                if (k != 0) ts = ts + 47'($urandom_range(0, 8));
                io = 16'($urandom);
                evq.push_back(ev(io, (k == n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, ts));
            end
            run_scn($sformatf("rand%0d", s), 64'($urandom_range(0, 30)));
        end

        prep(64'd0);
        e.io = 16'h00A5;
        e.p  = 64'd3;
        sb.push_back(e);
        fifo.push_back(ev(16'h00A5, 1'b0, 47'd3));
        fifo.push_back(ev(16'h0F0F, 1'b0, 47'd1000));
        tick;
        do_start();
        wait_drain("stop_setup");
        i_cmd_stop  = 1;
        i_cmd_start = 1;
        tick;
        i_cmd_stop  = 0;
        i_cmd_start = 0;
        chk("stop_state", {61'd0, o_state}, 64'd0);
        chk("stop_oe", {63'd0, o_io_oe}, 64'd0);
        chk("stop_io_hold", {48'd0, o_io_out}, 64'h00A5);
        chk("stop_played_hold", {32'd0, o_played}, 64'd1);

        do_start();
        repeat (10) tick;
        chk("pre_reset_oe", {63'd0, o_io_oe}, 64'd1);
        resetn = 0;
        tick;
        chk_reset("midrun_reset");
        resetn = 1;
        fifo.delete();
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
